// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: opcodes, Funct codes,
// state codes, ALUCtrl codes and the Moore output table indexed by state.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_NOP = 4'b1111;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_BRANCH = 4'd9,
        ST_JUMP   = 4'd10,
        ST_ADDIEX = 4'd11,
        ST_ADDIWB = 4'd12,
        ST_TRAP   = 4'd13
    } state_t;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_ctrl;
        logic [1:0] pc_source;
    } ctrl_out_t;

    localparam ctrl_out_t CTRL_QUIET = '{alu_ctrl: ALU_NOP, default: '0};

    // EXEC's ALUCtrl and BRANCH's PCEn depend on live inputs, so the top overlays them.
    function automatic ctrl_out_t state_outputs(input state_t s);
        ctrl_out_t o;
        o = CTRL_QUIET;
        case (s)
            ST_FETCH: begin
                o.mem_read  = 1'b1;
                o.ir_write  = 1'b1;
                o.pc_en     = 1'b1;
                o.alu_src_b = SRCB_FOUR;
                o.alu_ctrl  = ALU_ADD;
            end
            ST_DECODE: begin
                o.alu_src_b = SRCB_IMM_SH2;
                o.alu_ctrl  = ALU_ADD;
            end
            ST_MEMADR, ST_ADDIEX: begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = SRCB_IMM;
                o.alu_ctrl  = ALU_ADD;
            end
            ST_MEMRD: begin
                o.mem_read = 1'b1;
                o.iord     = 1'b1;
            end
            ST_MEMWB: begin
                o.reg_write  = 1'b1;
                o.mem_to_reg = 1'b1;
            end
            ST_MEMWR: begin
                o.mem_write = 1'b1;
                o.iord      = 1'b1;
            end
            ST_EXEC: begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = SRCB_REGB;
            end
            ST_ALUWB: begin
                o.reg_dst   = 1'b1;
                o.reg_write = 1'b1;
            end
            ST_BRANCH: begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = SRCB_REGB;
                o.alu_ctrl  = ALU_SUB;
                o.pc_source = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                o.pc_source = PCSRC_JUMP;
                o.pc_en     = 1'b1;
            end
            ST_ADDIWB: begin
                o.reg_write = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational Funct -> ALUCtrl map for R-type instructions in EXEC.
module alu_ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [3:0] alu_ctrl_o
);

    always_comb begin
        case (funct_i)
            FN_ADD:  alu_ctrl_o = ALU_ADD;
            FN_SUB:  alu_ctrl_o = ALU_SUB;
            default: alu_ctrl_o = ALU_NOP;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle main controller for the 32-bit MIPS-subset datapath (Moore FSM, registered outputs).
// Define ILLEGAL_OP_TRAP_EN to trap unknown opcodes in TRAP and expose the Illegal port.
module mc_control_fsm
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUCtrl,
    output logic [1:0] PCSource,
    output logic [3:0] StateOut
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    output logic       Illegal
`endif
);

    state_t    state_q;
    state_t    state_d;
    ctrl_out_t out_q;
    logic [3:0] exec_alu_ctrl;

    alu_ctrl_decode u_alu_ctrl_decode (
        .funct_i    (Funct),
        .alu_ctrl_o (exec_alu_ctrl)
    );

    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = ST_EXEC;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    OP_ADDI:      state_d = ST_ADDIEX;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:      state_d = ST_TRAP;
`else
                    default:      state_d = ST_FETCH;
`endif
                endcase
            end
            // Opcode is looked at again here to split lw from sw.
            ST_MEMADR: begin
                if (Opcode == OP_LW) begin
                    state_d = ST_MEMRD;
                end else if (Opcode == OP_SW) begin
                    state_d = ST_MEMWR;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEMRD:  state_d = ST_MEMWB;
            ST_MEMWB:  state_d = ST_FETCH;
            ST_MEMWR:  state_d = ST_FETCH;
            ST_EXEC:   state_d = ST_ALUWB;
            ST_ALUWB:  state_d = ST_FETCH;
            ST_BRANCH: state_d = ST_FETCH;
            ST_JUMP:   state_d = ST_FETCH;
            ST_ADDIEX: state_d = ST_ADDIWB;
            ST_ADDIWB: state_d = ST_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
            ST_TRAP:   state_d = ST_TRAP;
`endif
            default:   state_d = ST_FETCH;
        endcase
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_q;
`endif

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            out_q     <= CTRL_QUIET;
`ifdef ILLEGAL_OP_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            out_q     <= state_outputs(state_d);
`ifdef ILLEGAL_OP_TRAP_EN
            illegal_q <= (state_d == ST_TRAP);
`endif
        end
    end

`ifdef ILLEGAL_OP_TRAP_EN
    assign Illegal = illegal_q;
`endif

    assign PCEn     = out_q.pc_en | ((state_q == ST_BRANCH) & Zero);
    assign ALUCtrl  = (state_q == ST_EXEC) ? exec_alu_ctrl : out_q.alu_ctrl;
    assign IorD     = out_q.iord;
    assign MemRead  = out_q.mem_read;
    assign MemWrite = out_q.mem_write;
    assign IRWrite  = out_q.ir_write;
    assign RegDst   = out_q.reg_dst;
    assign MemtoReg = out_q.mem_to_reg;
    assign RegWrite = out_q.reg_write;
    assign ALUSrcA  = out_q.alu_src_a;
    assign ALUSrcB  = out_q.alu_src_b;
    assign PCSource = out_q.pc_source;
    assign StateOut = state_q;

endmodule
